tree_loader: RTL and testbench
==============================

Name: tree_loader

Overview:
- Upstream configuration stage for decision_tree_pipelined.
- Receives a byte stream (valid/ready) carrying a framed, checksummed tree image and unpacks each record into the node-write port (sw_we, sw_addr, sw_data_*).
- Reports load completion or failure, so the control plane only raises start once the tree is valid.

Parameters:
- MAX_NODES, 64, node memory depth; a record address >= MAX_NODES is an error.
- ADDR_WIDTH, 6, node index width; fixed at 6 by the record format.
- TIMEOUT_CYCLES, 1024, maximum idle cycles between bytes inside a frame before abort.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_data  in  8  stream byte
- in_valid  in  1  byte valid
- in_ready  out  1  loader can accept a byte
- sw_we  out  1  one-cycle node write strobe
- sw_addr  out  ADDR_WIDTH  node index
- sw_data_is_leaf  out  1  node is a leaf
- sw_data_threshold  out  8  compare value
- sw_data_less_than  out  1  1 = "input < threshold", 0 = "input > threshold"
- sw_data_left_idx  out  ADDR_WIDTH  child index when compare is true
- sw_data_right_idx  out  ADDR_WIDTH  child index when compare is false
- sw_data_action  out  2  leaf action
- busy  out  1  frame in progress
- tree_ready  out  1  last frame loaded with good checksum
- load_error  out  1  last frame failed

Behaviour:
- Reset (asynchronous, active-high): all outputs are 0 except in_ready=1; state is IDLE.
- Byte transfer: a byte is accepted on a rising clk edge where in_valid && in_ready.
- Frame format:
  - 0xA5 header
  - COUNT byte
  - COUNT records of 4 bytes each: ADDR, W2, W1, W0, forming a 24-bit word MSB first
  - CSUM byte
- Record word bit fields: [23]=is_leaf, [22]=less_than, [21:20]=action, [19:14]=left, [13:8]=right, [7:0]=threshold. ADDR[5:0] is the node index; ADDR[7:6] must be 0.
- Checksum: CSUM must equal the XOR of every byte after the header (COUNT through the last W0).
- States: IDLE, COUNT, ADDR, W2, W1, W0, WRITE, CSUM.
  - IDLE: bytes other than 0xA5 are accepted and dropped. On 0xA5: clear tree_ready and load_error, set busy, go to COUNT.
  - COUNT: if COUNT > MAX_NODES, error. If COUNT == 0, go to CSUM; otherwise go to ADDR.
  - ADDR: if the address is out of range (>= MAX_NODES or ADDR[7:6] != 0), error. Otherwise go to W2.
  - W2 -> W1 -> W0: shift in data bytes. After W0 is accepted, go to WRITE.
  - WRITE: in_ready=0 and sw_we=1 for exactly one cycle. All sw_* fields are registered and held stable from WRITE until the next WRITE. Decrement the remaining count; go to ADDR if records remain, else CSUM.
  - CSUM: on match, set tree_ready=1; on mismatch, set load_error=1. Clear busy and return to IDLE.
- Error (any state): set load_error=1, clear busy, return to IDLE. Records already written stay in memory, but tree_ready remains 0.
- Inside a frame, 0xA5 is treated as ordinary data; there is no resync.
- Timeout: an idle counter resets on every accepted byte. If it reaches TIMEOUT_CYCLES while busy, that is an error. The counter never runs in IDLE.
- Duplicate ADDR values within one frame are legal; the last write wins.
- in_ready=0 only in WRITE; in every other state in_ready=1.
- Latency: sw_we fires 1 cycle after the W0 byte is accepted. tree_ready/load_error update 1 cycle after CSUM is accepted.
- Reset mid-frame: takes effect immediately; no further sw_we, and tree_ready=0.

Decomposition:
- Shared package tree_pkg:
  - node_t struct (is_leaf, threshold, less_than, left_idx, right_idx, action)
  - action_e (NONE=0, BUY=1, SELL=2, CANCEL=3)
  - constants FRAME_HDR=8'hA5, REC_BYTES=4
  - a function unpacking a 24-bit word into node_t
- Reuse across the codebase: decision_tree_pipelined imports node_t and action_e from tree_pkg.
- Structure: a single module with no sub-module. The timeout counter is inline.

Test Plan:
- Single-record frame: A5 01 00 40 42 0A 09 -> one sw_we with addr=0, is_leaf=0, thr=10, less_than=1, L=1, R=2, act=0; then tree_ready=1.
- Full 7-node tree (root 0x40420A, leaf 3 = 03 90 00 00 BUY, ...) loaded, then driven into decision_tree_pipelined -> input 5 gives BUY (1), input 15 gives CANCEL (3).
- Bad checksum (last byte 0x08 instead of 0x09) -> sw_we still pulses once; load_error=1, tree_ready=0.
- COUNT=0x41, or ADDR=0x40 -> immediate load_error=1, no sw_we, busy=0.
- Stall 1024 cycles after W1 -> load_error=1, busy=0. A following valid frame loads cleanly and clears load_error.
- Stimulus edge cases:
  - in_valid held high through WRITE -> in_ready=0 for exactly one cycle and no byte is lost.
  - Garbage bytes 00 FF before the header -> dropped.
  - rst asserted mid-record -> outputs return to reset values at once.

Source files
------------

// File: rtl/tree_pkg.sv
// Shared tree-node definitions.
// Used by tree_loader (which writes nodes) and decision_tree_pipelined
// (which walks them). Holds the node record layout, the leaf action
// encoding, the frame constants and the 24-bit record-word unpacker.
package tree_pkg;

    localparam int NODE_IDX_W = 6;

    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int         REC_BYTES = 4;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        BUY    = 2'd1,
        SELL   = 2'd2,
        CANCEL = 2'd3
    } action_e;

    typedef struct packed {
        logic                  is_leaf;
        logic [7:0]            threshold;
        logic                  less_than;
        logic [NODE_IDX_W-1:0] left_idx;
        logic [NODE_IDX_W-1:0] right_idx;
        action_e               action;
    } node_t;

    // Word layout: [23] leaf, [22] less_than, [21:20] action,
    // [19:14] left, [13:8] right, [7:0] threshold.
    function automatic node_t unpack_node(input logic [23:0] word);
        node_t n;
        n.is_leaf   = word[23];
        n.less_than = word[22];
        n.action    = action_e'(word[21:20]);
        n.left_idx  = word[19:14];
        n.right_idx = word[13:8];
        n.threshold = word[7:0];
        return n;
    endfunction

endpackage

// File: rtl/tree_loader.sv
// Tree image loader.
// Accepts a framed, checksummed byte stream and turns each 4-byte record
// into a one-cycle node write.
//   clk, rst           : clock, asynchronous active-high reset
//   in_data/in_valid   : stream byte and its valid
//   in_ready           : low only during the single WRITE cycle
//   sw_we, sw_addr     : node write strobe and node index
//   sw_data_*          : unpacked node fields, held until the next write
//   busy               : a frame is in progress
//   tree_ready         : last frame loaded with a good checksum
//   load_error         : last frame was rejected or timed out
module tree_loader
    import tree_pkg::*;
#(
    parameter int MAX_NODES      = 64,
    parameter int ADDR_WIDTH     = 6,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  sw_we,
    output logic [ADDR_WIDTH-1:0] sw_addr,
    output logic                  sw_data_is_leaf,
    output logic [7:0]            sw_data_threshold,
    output logic                  sw_data_less_than,
    output logic [ADDR_WIDTH-1:0] sw_data_left_idx,
    output logic [ADDR_WIDTH-1:0] sw_data_right_idx,
    output logic [1:0]            sw_data_action,
    output logic                  busy,
    output logic                  tree_ready,
    output logic                  load_error
);

    typedef enum logic [2:0] {
        IDLE, COUNT, ADDR, W2, W1, W0, WRITE, CSUM
    } state_e;

    localparam int              CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [8:0]      MAX_NODES_W = 9'(MAX_NODES);
    localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                state;
    logic [7:0]            csum;
    logic [7:0]            remaining;
    logic [CNT_W-1:0]      idle_cnt;
    logic [7:0]            w2_byte;
    logic [7:0]            w1_byte;
    logic [ADDR_WIDTH-1:0] rec_addr;
    node_t                 node;

    logic accept;
    logic timed_out;
    logic count_bad;
    logic addr_bad;

    assign accept    = in_valid && in_ready;
    // The idle counter is about to reach the limit on this edge.
    assign timed_out = busy && !accept && (idle_cnt == IDLE_LIMIT);
    assign count_bad = {1'b0, in_data} > MAX_NODES_W;
    assign addr_bad  = ({1'b0, in_data} >= MAX_NODES_W) || (in_data[7:6] != 2'b00);

    assign sw_data_is_leaf   = node.is_leaf;
    assign sw_data_threshold = node.threshold;
    assign sw_data_less_than = node.less_than;
    assign sw_data_left_idx  = node.left_idx;
    assign sw_data_right_idx = node.right_idx;
    assign sw_data_action    = node.action;

    // Record bytes staged until the word is complete; no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            unique case (state)
                ADDR:    rec_addr <= in_data[ADDR_WIDTH-1:0];
                W2:      w2_byte  <= in_data;
                W1:      w1_byte  <= in_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            sw_we      <= 1'b0;
            sw_addr    <= '0;
            node       <= '0;
            busy       <= 1'b0;
            tree_ready <= 1'b0;
            load_error <= 1'b0;
            csum       <= '0;
            remaining  <= '0;
            idle_cnt   <= '0;
        end else begin
            sw_we <= 1'b0;

            if (!busy || accept) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (timed_out) begin
                state      <= IDLE;
                busy       <= 1'b0;
                load_error <= 1'b1;
                in_ready   <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept && in_data == FRAME_HDR) begin
                            tree_ready <= 1'b0;
                            load_error <= 1'b0;
                            busy       <= 1'b1;
                            csum       <= '0;
                            state      <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (accept) begin
                            csum      <= in_data;
                            remaining <= in_data;
                            if (count_bad) begin
                                state      <= IDLE;
                                busy       <= 1'b0;
                                load_error <= 1'b1;
                            end else if (in_data == 8'd0) begin
                                state <= CSUM;
                            end else begin
                                state <= ADDR;
                            end
                        end
                    end
                    ADDR: begin
                        if (accept) begin
                            csum <= csum ^ in_data;
                            if (addr_bad) begin
                                state      <= IDLE;
                                busy       <= 1'b0;
                                load_error <= 1'b1;
                            end else begin
                                state <= W2;
                            end
                        end
                    end
                    W2: begin
                        if (accept) begin
                            csum  <= csum ^ in_data;
                            state <= W1;
                        end
                    end
                    W1: begin
                        if (accept) begin
                            csum  <= csum ^ in_data;
                            state <= W0;
                        end
                    end
                    W0: begin
                        if (accept) begin
                            csum     <= csum ^ in_data;
                            node     <= unpack_node({w2_byte, w1_byte, in_data});
                            sw_addr  <= rec_addr;
                            sw_we    <= 1'b1;
                            in_ready <= 1'b0;
                            state    <= WRITE;
                        end
                    end
                    WRITE: begin
                        in_ready  <= 1'b1;
                        remaining <= remaining - 8'd1;
                        state     <= (remaining == 8'd1) ? CSUM : ADDR;
                    end
                    CSUM: begin
                        if (accept) begin
                            if (in_data == csum) begin
                                tree_ready <= 1'b1;
                            end else begin
                                load_error <= 1'b1;
                            end
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tree_loader.sv
module tb_tree_loader;

    localparam int MAXN = 64;
    localparam int AW   = 6;
    localparam int TO   = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          sw_we;
    logic [AW-1:0] sw_addr;
    logic          sw_data_is_leaf;
    logic [7:0]    sw_data_threshold;
    logic          sw_data_less_than;
    logic [AW-1:0] sw_data_left_idx;
    logic [AW-1:0] sw_data_right_idx;
    logic [1:0]    sw_data_action;
    logic          busy;
    logic          tree_ready;
    logic          load_error;

    tree_loader #(.MAX_NODES(MAXN), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sw_we(sw_we), .sw_addr(sw_addr),
        .sw_data_is_leaf(sw_data_is_leaf), .sw_data_threshold(sw_data_threshold),
        .sw_data_less_than(sw_data_less_than), .sw_data_left_idx(sw_data_left_idx),
        .sw_data_right_idx(sw_data_right_idx), .sw_data_action(sw_data_action),
        .busy(busy), .tree_ready(tree_ready), .load_error(load_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [5:0]  addr;
        logic [23:0] word;
    } wr_t;

    // Write log and stall count, observed on the falling edge.
    wr_t wr_log[$];
    int  stall_total = 0;

    always @(negedge clk) begin
        if (rst == 1'b0) begin
            if (sw_we)
                wr_log.push_back({sw_addr, sw_data_is_leaf, sw_data_less_than, sw_data_action,
                                  sw_data_left_idx, sw_data_right_idx, sw_data_threshold});
            if (in_valid && !in_ready)
                stall_total++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        logic ok;
        ok       = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 8; t++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("byte_accept_timeout", 32'(ok), 32'd1);
    endtask

    logic [7:0] frame[$];

    task automatic send_frame(input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            send_byte(frame[i]);
            if (gap_max > 0) begin
                int g;
                g = $urandom_range(0, gap_max);
                if (g > 0) begin
                    in_valid = 1'b0;
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // Reference: parse a frame from the format rules.
    wr_t        exp_wr[$];
    logic       exp_tr;
    logic       exp_le;
    int         exp_n;

    task automatic run_model();
        int         i;
        int         cnt;
        logic [7:0] x;
        logic [7:0] a;
        exp_wr.delete();
        exp_tr = 1'b0;
        exp_le = 1'b0;
        i = 0;
        while (frame[i] != 8'hA5) i++;
        i++;
        cnt = int'(frame[i]);
        x   = frame[i];
        i++;
        if (cnt > MAXN) begin
            exp_le = 1'b1;
            exp_n  = i;
            return;
        end
        for (int r = 0; r < cnt; r++) begin
            a = frame[i];
            x = x ^ a;
            i++;
            if (int'(a) >= MAXN) begin
                exp_le = 1'b1;
                exp_n  = i;
                return;
            end
            exp_wr.push_back({a[5:0], frame[i], frame[i+1], frame[i+2]});
            x = x ^ frame[i] ^ frame[i+1] ^ frame[i+2];
            i += 3;
        end
        if (frame[i] == x) exp_tr = 1'b1;
        else               exp_le = 1'b1;
        exp_n = i + 1;
    endtask

    typedef struct {
        logic [127:0] bytes;
        int           len;
        int           nwr;
        logic [5:0]   a0;
        logic [23:0]  w0;
        logic         tr;
        logic         le;
    } vec_t;

    vec_t vt[10];

    logic [23:0] mmem[MAXN];
    logic [23:0] dmem[MAXN];

    initial begin
        int base;
        int s0;
        int rbase;
        logic [7:0] x;
        logic [7:0] cnt;
        logic [7:0] b;

        vt[0] = '{128'hA5_01_00_40_42_0A_09,             7,  1, 6'd0,  24'h40420A, 1'b1, 1'b0};
        vt[1] = '{128'hA5_01_00_40_42_0A_08,             7,  1, 6'd0,  24'h40420A, 1'b0, 1'b1};
        vt[2] = '{128'hA5_41,                            2,  0, 6'd0,  24'h000000, 1'b0, 1'b1};
        vt[3] = '{128'hA5_01_40,                         3,  0, 6'd0,  24'h000000, 1'b0, 1'b1};
        vt[4] = '{128'h00_FF_A5_01_03_90_00_00_92,       9,  1, 6'd3,  24'h900000, 1'b1, 1'b0};
        vt[5] = '{128'hA5_00_00,                         3,  0, 6'd0,  24'h000000, 1'b1, 1'b0};
        vt[6] = '{128'hA5_01_3F_12_34_56_4E,             7,  1, 6'd63, 24'h123456, 1'b1, 1'b0};
        vt[7] = '{128'hA5_01_80,                         3,  0, 6'd0,  24'h000000, 1'b0, 1'b1};
        vt[8] = '{128'hA5_02_05_00_00_01_05_00_00_02_01, 11, 2, 6'd5,  24'h000001, 1'b1, 1'b0};
        vt[9] = '{128'hA5_01_01_00_00_A5_A5,             7,  1, 6'd1,  24'h0000A5, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_sw_we", 32'(sw_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tree_ready", 32'(tree_ready), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
        check("rst_fields", {sw_addr, sw_data_threshold, sw_data_left_idx, sw_data_right_idx,
                             sw_data_action}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single record byte by byte: write latency and field decode
        send_byte(8'hA5);
        check("hdr_busy", 32'(busy), 32'd1);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h40);
        send_byte(8'h42);
        send_byte(8'h0A);
        check("lat_sw_we", 32'(sw_we), 32'd1);
        check("lat_in_ready_low", 32'(in_ready), 32'd0);
        check("lat_fields", {sw_addr, sw_data_is_leaf, sw_data_threshold, sw_data_less_than,
                             sw_data_left_idx, sw_data_right_idx, sw_data_action},
              {6'd0, 1'b0, 8'd10, 1'b1, 6'd1, 6'd2, 2'd0});
        send_byte(8'h09);
        in_valid = 1'b0;
        check("lat_tree_ready", 32'(tree_ready), 32'd1);
        check("lat_busy_clear", 32'(busy), 32'd0);
        check("held_threshold", 32'(sw_data_threshold), 32'h0A);
        check("held_sw_we_low", 32'(sw_we), 32'd0);

        // Table vectors, in_valid held high through each frame
        for (int v = 0; v < 10; v++) begin
            base = wr_log.size();
            s0   = stall_total;
            frame.delete();
            for (int i = 0; i < vt[v].len; i++)
                frame.push_back(vt[v].bytes[(vt[v].len - 1 - i) * 8 +: 8]);
            send_frame(vt[v].len, 0);
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("v%0d_nwr", v), 32'(wr_log.size() - base), 32'(vt[v].nwr));
            if (vt[v].nwr > 0 && wr_log.size() > base)
                check($sformatf("v%0d_wr0", v), 32'(wr_log[base]), 32'({vt[v].a0, vt[v].w0}));
            check($sformatf("v%0d_stalls", v), 32'(stall_total - s0), 32'(vt[v].nwr));
            check($sformatf("v%0d_tree_ready", v), 32'(tree_ready), 32'(vt[v].tr));
            check($sformatf("v%0d_load_error", v), 32'(load_error), 32'(vt[v].le));
            check($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
            check($sformatf("v%0d_in_ready", v), 32'(in_ready), 32'd1);
            if (v == 8 && wr_log.size() > base + 1)
                check("dup_last_wins", 32'(wr_log[base + 1]), 32'({6'd5, 24'h000002}));
        end

        // Timeout after W1, then clean recovery
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h40);
        send_byte(8'h42);
        in_valid = 1'b0;
        repeat (TO - 1) @(posedge clk);
        #1;
        check("to_still_busy", 32'(busy), 32'd1);
        check("to_no_error_yet", 32'(load_error), 32'd0);
        @(posedge clk);
        #1;
        check("to_load_error", 32'(load_error), 32'd1);
        check("to_busy_clear", 32'(busy), 32'd0);
        base = wr_log.size();
        frame = '{8'hA5, 8'h01, 8'h00, 8'h40, 8'h42, 8'h0A, 8'h09};
        send_frame(7, 0);
        @(posedge clk);
        #1;
        check("rec_tree_ready", 32'(tree_ready), 32'd1);
        check("rec_load_error", 32'(load_error), 32'd0);
        check("rec_nwr", 32'(wr_log.size() - base), 32'd1);

        // Reset asserted mid-record
        base = wr_log.size();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h07);
        send_byte(8'h81);
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_status", {tree_ready, load_error, sw_we}, 32'd0);
        check("mid_rst_fields", {sw_addr, sw_data_threshold, sw_data_left_idx}, 32'd0);
        #1 rst = 1'b0;
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_no_write", 32'(wr_log.size() - base), 32'd0);
        check("mid_rst_idle", {busy, tree_ready, load_error}, 32'd0);

        // Randomized frames against the reference parser
        for (int a = 0; a < MAXN; a++) begin
            mmem[a] = 24'h0;
            dmem[a] = 24'h0;
        end
        rbase = wr_log.size();
        for (int r = 0; r < 40; r++) begin
            frame.delete();
            repeat ($urandom_range(0, 2)) frame.push_back(8'($urandom_range(0, 8'hA4)));
            frame.push_back(8'hA5);
            if (r == 0)                          cnt = 8'd64;
            else if ($urandom_range(0, 19) == 0) cnt = 8'($urandom_range(65, 255));
            else                                 cnt = 8'($urandom_range(0, 6));
            frame.push_back(cnt);
            x = cnt;
            if (int'(cnt) <= MAXN) begin
                for (int k = 0; k < int'(cnt); k++) begin
                    if (r != 0 && $urandom_range(0, 14) == 0) b = 8'($urandom_range(64, 255));
                    else                                      b = 8'($urandom_range(0, 63));
                    frame.push_back(b);
                    x = x ^ b;
                    repeat (3) begin
                        b = 8'($urandom_range(0, 255));
                        frame.push_back(b);
                        x = x ^ b;
                    end
                end
                if ($urandom_range(0, 4) == 0) x = x ^ 8'($urandom_range(1, 255));
                frame.push_back(x);
            end
            run_model();
            base = wr_log.size();
            send_frame(exp_n, 2);
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("r%0d_nwr", r), 32'(wr_log.size() - base), 32'(exp_wr.size()));
            for (int k = 0; k < exp_wr.size(); k++) begin
                if (base + k < wr_log.size())
                    check($sformatf("r%0d_wr%0d", r, k), 32'(wr_log[base + k]), 32'(exp_wr[k]));
                mmem[exp_wr[k].addr] = exp_wr[k].word;
            end
            check($sformatf("r%0d_status", r), {busy, tree_ready, load_error},
                  {1'b0, exp_tr, exp_le});
        end
        for (int k = rbase; k < wr_log.size(); k++)
            dmem[wr_log[k].addr] = wr_log[k].word;
        for (int a = 0; a < MAXN; a++)
            check($sformatf("mem%0d", a), 32'(dmem[a]), 32'(mmem[a]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
